// File: rtl/apu_pkg.sv
// Shared types and constants for the APU frame sequencer.
//   step_t         : 3-bit index into the 8-step frame sequence
//   apu_strobes_t  : bundle of the length/sweep/envelope strobes for fan-out
//   step_strobes() : strobes produced when a given step executes
package apu_pkg;

  localparam int unsigned STEP_W = 3;

  typedef logic [STEP_W-1:0] step_t;

  localparam step_t       STEP_ENV      = 3'd7;
  localparam logic [7:0]  STEP256_MASK  = 8'b0101_0101;
  localparam logic [7:0]  STEP128_MASK  = 8'b0100_0100;

  typedef struct packed {
    logic clk256;
    logic clk128;
    logic clk64;
  } apu_strobes_t;

  // Strobes raised when step s is executed.
  function automatic apu_strobes_t step_strobes(input step_t s);
    apu_strobes_t r;
    r.clk256 = STEP256_MASK[s];
    r.clk128 = STEP128_MASK[s];
    r.clk64  = (s == STEP_ENV);
    return r;
  endfunction

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Signal bundle between the DIV/power logic, the frame sequencer and its consumers.
//   slow_clk_en, div_bit, apu_on        : sequencer inputs
//   clk256_en, clk128_en, clk64_en      : registered strobes
//   step, length_first_half             : next-step information
// modport slave  : the sequencer
// modport master : the environment driving it
interface apu_frame_sequencer_if;
  import apu_pkg::*;

  logic  slow_clk_en;
  logic  div_bit;
  logic  apu_on;
  logic  clk256_en;
  logic  clk128_en;
  logic  clk64_en;
  step_t step;
  logic  length_first_half;

  modport slave (
    input  slow_clk_en, div_bit, apu_on,
    output clk256_en, clk128_en, clk64_en, step, length_first_half
  );

  modport master (
    output slow_clk_en, div_bit, apu_on,
    input  clk256_en, clk128_en, clk64_en, step, length_first_half
  );

endinterface

// File: rtl/apu_frame_tick_gen.sv
// 512 Hz tick source for the frame sequencer.
// Default build: falling-edge detector on div_bit, sampled on slow_clk_en cycles.
// With APU_FRAME_SEQ_INTERNAL_DIV_EN defined: a DIV_WIDTH-bit counter fires every
// TICK_DIV slow cycles while powered, and div_bit is ignored.
// Ports:
//   clk, reset_n    : clock, async active-low reset
//   i_slow_clk_en   : APU clock enable
//   i_div_bit       : selected DIV bit
//   i_apu_on        : APU power
//   o_tick_c        : single-cycle tick, qualified by slow_clk_en and apu_on
module apu_frame_tick_gen #(
  parameter int unsigned TICK_DIV  = 8192,
  parameter int unsigned DIV_WIDTH = 13
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_slow_clk_en,
  input  logic i_div_bit,
  input  logic i_apu_on,
  output logic o_tick_c
);

  // Divider must be wide enough to reach TICK_DIV-1.
  if (DIV_WIDTH < 32 && (32'd1 << DIV_WIDTH) < TICK_DIV) begin : g_div_width_check
    $error("apu_frame_tick_gen: DIV_WIDTH too small for TICK_DIV");
  end

`ifdef APU_FRAME_SEQ_INTERNAL_DIV_EN

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 w_wrap;
  logic                 w_unused_div_bit;

  assign w_unused_div_bit = i_div_bit;
  assign w_wrap           = (r_div_cnt == DIV_WIDTH'(TICK_DIV - 1));

  // Free-running divider, parked at 0 while powered off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (!i_apu_on) begin
      r_div_cnt <= '0;
    end else if (i_slow_clk_en) begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + DIV_WIDTH'(1);
    end
  end

  assign o_tick_c = i_slow_clk_en & i_apu_on & w_wrap;

`else

  logic r_div_prev;

  // Tracks div_bit even while powered off so power-up sees no false edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_prev <= 1'b0;
    end else if (i_slow_clk_en) begin
      r_div_prev <= i_div_bit;
    end
  end

  assign o_tick_c = i_slow_clk_en & i_apu_on & r_div_prev & ~i_div_bit;

`endif

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 8-step sequence advanced by 512 Hz ticks, producing the
// 256 Hz length, 128 Hz sweep and 64 Hz envelope strobes.
// Strobes are set on the tick's slow cycle and cleared at the end of the next
// slow cycle, so slow_clk_en & strobe gives exactly one event per tick.
// Optional macro: APU_FRAME_SEQ_INTERNAL_DIV_EN (internal divider replaces div_bit).
// Ports:
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : slow_clk_en/div_bit/apu_on in; strobes, step, length_first_half out
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 8192,
  parameter int unsigned DIV_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  apu_frame_sequencer_if.slave  bus
);

  logic         w_tick;
  step_t        r_step;
  step_t        w_step_nxt;
  apu_strobes_t r_strobes;
  apu_strobes_t w_strobes_nxt;

  apu_frame_tick_gen #(
    .TICK_DIV  (TICK_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_slow_clk_en (bus.slow_clk_en),
    .i_div_bit     (bus.div_bit),
    .i_apu_on      (bus.apu_on),
    .o_tick_c      (w_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step    <= '0;
      r_strobes <= '0;
    end else begin
      r_step    <= w_step_nxt;
      r_strobes <= w_strobes_nxt;
    end
  end

  // Next state: power-off overrides everything; a tick beats the pending clear.
  always_comb begin
    w_step_nxt    = r_step;
    w_strobes_nxt = r_strobes;
    if (!bus.apu_on) begin
      w_step_nxt    = '0;
      w_strobes_nxt = '0;
    end else if (bus.slow_clk_en) begin
      w_strobes_nxt = '0;
      if (w_tick) begin
        w_strobes_nxt = step_strobes(r_step);
        w_step_nxt    = r_step + STEP_W'(1);
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.clk256_en         = r_strobes.clk256;
    bus.clk128_en         = r_strobes.clk128;
    bus.clk64_en          = r_strobes.clk64;
    bus.step              = r_step;
    bus.length_first_half = r_step[0];
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer: directed scenarios plus random
// traffic, all compared against a tick-counting reference model.
module tb_apu_frame_sequencer;

  localparam int unsigned TICK_DIV  = 8;
  localparam int unsigned DIV_WIDTH = 4;

  logic clk = 1'b0;
  logic reset_n;

  apu_frame_sequencer_if bus ();

  apu_frame_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int gated   = 0;

  // Reference model: position in the 8-step frame and the strobes it expects.
  int   m_pos  = 0;
  int   m_cnt  = 0;
  logic m_prev = 1'b0;
  logic m_s256 = 1'b0;
  logic m_s128 = 1'b0;
  logic m_s64  = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_prev = 1'b0;
    m_s256 = 1'b0; m_s128 = 1'b0; m_s64 = 1'b0;
  endtask

  task automatic model_update(input logic se, input logic db, input logic on);
    logic tick;
    int   s;
    tick = 1'b0;
`ifdef APU_FRAME_SEQ_INTERNAL_DIV_EN
    if (!on) m_cnt = 0;
    else if (se) begin
      tick  = (m_cnt == TICK_DIV - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
    end
`else
    if (se) begin
      tick   = m_prev && !db;
      m_prev = db;
    end
`endif
    if (!on) begin
      m_pos = 0; m_s256 = 1'b0; m_s128 = 1'b0; m_s64 = 1'b0;
    end else if (se) begin
      m_s256 = 1'b0; m_s128 = 1'b0; m_s64 = 1'b0;
      if (tick) begin
        s      = m_pos;
        m_s256 = (s % 2 == 0);
        m_s128 = (s % 4 == 2);
        m_s64  = (s == 7);
        m_pos  = (m_pos + 1) % 8;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {2'b00, bus.step, bus.length_first_half, bus.clk256_en, bus.clk128_en, bus.clk64_en};
    exp = {2'b00, 3'(m_pos), 1'(m_pos % 2), m_s256, m_s128, m_s64};
    chk(tag, obs, exp);
  endtask

  // One clock: drive at negedge, count consumer events, model at posedge, check after.
  task automatic cyc(input logic se, input logic db, input logic on);
    @(negedge clk);
    bus.slow_clk_en = se;
    bus.div_bit     = db;
    bus.apu_on      = on;
    #1;
    if (se && bus.clk256_en) gated++;
    @(posedge clk);
    model_update(se, db, on);
    #1;
    check_model("cyc");
  endtask

  task automatic tick_pair();
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
  endtask

  int c256, c128, c64;

  initial begin
    reset_n         = 1'b0;
    bus.slow_clk_en = 1'b0;
    bus.div_bit     = 1'b0;
    bus.apu_on      = 1'b0;
    #1;
    chk("reset_state",
        {2'b00, bus.step, bus.length_first_half, bus.clk256_en, bus.clk128_en, bus.clk64_en},
        8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Full frame: eight ticks walk through the schedule.
    c256 = 0; c128 = 0; c64 = 0;
    for (int i = 0; i < 8; i++) begin
      tick_pair();
      c256 += int'(bus.clk256_en);
      c128 += int'(bus.clk128_en);
      c64  += int'(bus.clk64_en);
    end
`ifndef APU_FRAME_SEQ_INTERNAL_DIV_EN
    chk("frame_256_count", 8'(c256), 8'd4);
    chk("frame_128_count", 8'(c128), 8'd2);
    chk("frame_64_count",  8'(c64),  8'd1);
    chk("frame_step_wrap", 8'(bus.step), 8'd0);
`endif

    // Sparse clock enable: strobe holds until the next enabled cycle.
    cyc(1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    gated = 0;
    cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
`ifndef APU_FRAME_SEQ_INTERNAL_DIV_EN
    chk("sparse_hold", 8'(bus.clk256_en), 8'd1);
`endif
    cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
`ifndef APU_FRAME_SEQ_INTERNAL_DIV_EN
    chk("sparse_gated", 8'(gated), 8'd1);
    chk("sparse_clear", 8'(bus.clk256_en), 8'd0);
`endif

    // Power cycle from step 5: first tick after power-up runs step 0.
    repeat (4) tick_pair();
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
`ifndef APU_FRAME_SEQ_INTERNAL_DIV_EN
    chk("pwr_lfh_before", 8'(bus.length_first_half), 8'd0);
`endif
    cyc(1'b1, 1'b0, 1'b1);
`ifndef APU_FRAME_SEQ_INTERNAL_DIV_EN
    chk("pwr_step0", {6'd0, bus.clk256_en, bus.clk128_en}, 8'b10);
    chk("pwr_lfh_after", 8'(bus.length_first_half), 8'd1);
`endif

    // Power-off coinciding with a falling edge.
    tick_pair();
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("off_edge",
        {2'b00, bus.step, bus.clk256_en, bus.clk128_en, bus.clk64_en, 1'b0}, 8'h00);
    cyc(1'b1, 1'b0, 1'b1);

    // Asynchronous reset while a strobe is pending.
    tick_pair();
    #3;
    reset_n     = 1'b0;
    bus.div_bit = 1'b1;
    #1;
    chk("async_reset",
        {2'b00, bus.step, bus.length_first_half, bus.clk256_en, bus.clk128_en, bus.clk64_en},
        8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    gated   = 0;
    repeat (4) cyc(1'b1, 1'b1, 1'b1);
    chk("post_reset_quiet", 8'(gated), 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
